// File: rtl/reg_file_8x16_if.sv
// Operand bus between the register file and its neighbours:
// read ports toward the ALU, write/flag ports from it.
interface reg_file_8x16_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 3,
   parameter int FW    = 4
);
   logic [AW-1:0]    ra_addr;
   logic [AW-1:0]    rb_addr;
   logic [WIDTH-1:0] ra_data;
   logic [WIDTH-1:0] rb_data;
   logic             we;
   logic [AW-1:0]    wa_addr;
   logic [WIDTH-1:0] wd;
   logic             fwe;
   logic [FW-1:0]    fin;
   logic [FW-1:0]    flags;
   logic [7:0]       wcount;

   modport master (
      output ra_addr, rb_addr, we, wa_addr, wd, fwe, fin,
      input  ra_data, rb_data, flags, wcount
   );

   modport slave (
      input  ra_addr, rb_addr, we, wa_addr, wd, fwe, fin,
      output ra_data, rb_data, flags, wcount
   );
endinterface

// File: rtl/reg_file_8x16.sv
// 8x16 register file with two bypassed read ports, one write
// port, a flag register and a committed-write counter.
module reg_file_8x16 #(
   parameter int WIDTH = 16,
   parameter int NREG  = 8,
   parameter int AW    = 3,
   parameter int FW    = 4
) (
   input logic            clk,
   input logic            rst,
   reg_file_8x16_if.slave bus
);
   logic [WIDTH-1:0] regs_q [NREG];
   logic [FW-1:0]    flags_q;
   logic [7:0]       wcount_q;
   logic [7:0]       wcount_d;
   logic [WIDTH-1:0] ra_rd;
   logic [WIDTH-1:0] rb_rd;

   assign wcount_d = wcount_q + 8'd1;

   // Reset wins over both write enables in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         flags_q  <= '0;
         wcount_q <= '0;
      end else begin
         if (bus.we) begin
            regs_q[bus.wa_addr] <= bus.wd;
            wcount_q            <= wcount_d;
         end
         if (bus.fwe) begin
            flags_q <= bus.fin;
         end
      end
   end

   // Same-cycle bypass so a result just produced feeds the ALU.
   always_comb begin
      ra_rd = '0;
      rb_rd = '0;
      if (!rst) begin
         if (bus.we && (bus.wa_addr == bus.ra_addr)) begin
            ra_rd = bus.wd;
         end else begin
            ra_rd = regs_q[bus.ra_addr];
         end
         if (bus.we && (bus.wa_addr == bus.rb_addr)) begin
            rb_rd = bus.wd;
         end else begin
            rb_rd = regs_q[bus.rb_addr];
         end
      end
   end

   assign bus.ra_data = ra_rd;
   assign bus.rb_data = rb_rd;
   assign bus.flags   = flags_q;
   assign bus.wcount  = wcount_q;
endmodule
